// File: rtl/eeprom_rw_test_ctrl.sv
// EEPROM write/read-back self test: writes BYTE_NUM pattern bytes, then reads and compares them.
// Optional ack watchdog enabled by defining EEPROM_TEST_TIMEOUT_EN.
module eeprom_rw_test_ctrl #(
   parameter int          BYTE_NUM       = 256,
   parameter logic [15:0] START_ADDR     = 16'h0000,
   parameter int          TWR_CYCLES     = 250000,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        drv_req,
   output logic        drv_wr,
   output logic [15:0] drv_addr,
   output logic [7:0]  drv_wdata,
   input  logic        drv_ack,
   input  logic [7:0]  drv_rdata,
   output logic        busy,
   output logic        rw_done,
   output logic        rw_res
);

   localparam logic [7:0]  PATTERN  = 8'hA5;
   localparam logic [15:0] LAST_OFF = 16'(BYTE_NUM - 1);
   localparam logic [31:0] TWR_LAST = 32'(TWR_CYCLES - 1);

   if (BYTE_NUM < 1 || BYTE_NUM > 65536 || TWR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
      $error("eeprom_rw_test_ctrl: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_TWR, RD_REQ, CHECK, DONE
   } state_t;

   state_t      state_q, state_n;
   logic [15:0] offset_q, offset_n;
   logic [31:0] twr_q, twr_n;
   logic [7:0]  rdata_q, rdata_n;
   logic        req_n, wr_n, busy_n, done_n, res_n;
   logic [15:0] addr_n;
   logic [7:0]  wdata_n;
   logic [15:0] off_inc;

`ifdef EEPROM_TEST_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] to_q, to_n;
`endif

   assign off_inc = offset_q + 16'd1;

   always_comb begin
      state_n  = state_q;
      offset_n = offset_q;
      twr_n    = twr_q;
      rdata_n  = rdata_q;
      req_n    = drv_req;
      wr_n     = drv_wr;
      addr_n   = drv_addr;
      wdata_n  = drv_wdata;
      busy_n   = busy;
      done_n   = rw_done;
      res_n    = rw_res;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_n  = WR_REQ;
               offset_n = 16'd0;
               twr_n    = 32'd0;
               req_n    = 1'b1;
               wr_n     = 1'b1;
               addr_n   = START_ADDR;
               wdata_n  = PATTERN;
               busy_n   = 1'b1;
               done_n   = 1'b0;
               res_n    = 1'b0;
            end
         end
         WR_REQ: begin
            if (drv_ack) begin
               req_n   = 1'b0;
               twr_n   = 32'd0;
               state_n = WR_TWR;
            end
         end
         WR_TWR: begin
            if (twr_q >= TWR_LAST) begin
               twr_n = 32'd0;
               req_n = 1'b1;
               if (offset_q == LAST_OFF) begin
                  offset_n = 16'd0;
                  state_n  = RD_REQ;
                  wr_n     = 1'b0;
                  addr_n   = START_ADDR;
               end else begin
                  offset_n = off_inc;
                  state_n  = WR_REQ;
                  wr_n     = 1'b1;
                  addr_n   = START_ADDR + off_inc;
                  wdata_n  = off_inc[7:0] ^ PATTERN;
               end
            end else begin
               twr_n = twr_q + 32'd1;
            end
         end
         RD_REQ: begin
            if (drv_ack) begin
               rdata_n = drv_rdata;
               req_n   = 1'b0;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (rdata_q != (offset_q[7:0] ^ PATTERN) || offset_q == LAST_OFF) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               res_n   = (rdata_q == (offset_q[7:0] ^ PATTERN));
            end else begin
               offset_n = off_inc;
               state_n  = RD_REQ;
               req_n    = 1'b1;
               wr_n     = 1'b0;
               addr_n   = START_ADDR + off_inc;
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef EEPROM_TEST_TIMEOUT_EN
      to_n = (drv_req && !drv_ack) ? to_q + 32'd1 : 32'd0;
      // a stuck driver ends the run as a failure
      if (drv_req && !drv_ack && to_q >= TO_LAST) begin
         to_n    = 32'd0;
         state_n = DONE;
         req_n   = 1'b0;
         busy_n  = 1'b0;
         done_n  = 1'b1;
         res_n   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         offset_q  <= 16'd0;
         twr_q     <= 32'd0;
         rdata_q   <= 8'd0;
         drv_req   <= 1'b0;
         drv_wr    <= 1'b0;
         drv_addr  <= 16'd0;
         drv_wdata <= 8'd0;
         busy      <= 1'b0;
         rw_done   <= 1'b0;
         rw_res    <= 1'b0;
      end else begin
         state_q   <= state_n;
         offset_q  <= offset_n;
         twr_q     <= twr_n;
         rdata_q   <= rdata_n;
         drv_req   <= req_n;
         drv_wr    <= wr_n;
         drv_addr  <= addr_n;
         drv_wdata <= wdata_n;
         busy      <= busy_n;
         rw_done   <= done_n;
         rw_res    <= res_n;
      end
   end

`ifdef EEPROM_TEST_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_q <= 32'd0;
      else        to_q <= to_n;
   end
`endif

endmodule

// File: tb/tb_eeprom_rw_test_ctrl.sv
// Scoreboard bench for eeprom_rw_test_ctrl: expected driver requests and run results are queued
// by the stimulus and checked by independent monitors.
module tb_eeprom_rw_test_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        drv_req, drv_wr, drv_ack;
   logic [15:0] drv_addr;
   logic [7:0]  drv_wdata, drv_rdata;
   logic        busy, rw_done, rw_res;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } req_t;

   req_t exp_q[$];
   logic res_q[$];

   logic [15:0] addr_tab [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
   logic [7:0]  data_tab [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

   logic [7:0]  mem [0:65535];
   logic        ack_en = 1'b1;
   logic        corrupt = 1'b0;
   logic [15:0] corrupt_addr = 16'h0000;

   eeprom_rw_test_ctrl #(
      .BYTE_NUM(4), .START_ADDR(16'hFFFE), .TWR_CYCLES(10), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .drv_req(drv_req), .drv_wr(drv_wr), .drv_addr(drv_addr), .drv_wdata(drv_wdata),
      .drv_ack(drv_ack), .drv_rdata(drv_rdata),
      .busy(busy), .rw_done(rw_done), .rw_res(rw_res)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // Driver model: acks three cycles after seeing a request, echoing memory on reads.
   initial begin
      drv_ack   = 1'b0;
      drv_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (drv_req && ack_en) begin
            logic        w;
            logic [15:0] a;
            logic [7:0]  d;
            w = drv_wr; a = drv_addr; d = drv_wdata;
            repeat (2) @(posedge clk);
            #1;
            if (w) mem[a] = d;
            else   drv_rdata = mem[a] ^ ((corrupt && a == corrupt_addr) ? 8'hFF : 8'h00);
            drv_ack = 1'b1;
            @(posedge clk);
            #1 drv_ack = 1'b0;
         end
      end
   end

   // Request monitor: each new request is popped against the expected queue.
   logic req_seen = 1'b0;
   always @(negedge clk) begin
      if (!drv_req) begin
         req_seen = 1'b0;
      end else if (!req_seen) begin
         req_seen = 1'b1;
         if (exp_q.size() == 0) begin
            fail_now($sformatf("unexpected_req wr=%0b addr=%0h", drv_wr, drv_addr));
         end else begin
            req_t e;
            e = exp_q.pop_front();
            check("req_wr", 32'(drv_wr), 32'(e.wr));
            check("req_addr", 32'(drv_addr), 32'(e.addr));
            if (e.wr) check("req_wdata", 32'(drv_wdata), 32'(e.wdata));
         end
      end
   end

   // Result monitor: each completed run is popped against the expected result queue.
   logic done_d = 1'b0;
   always @(negedge clk) begin
      if (rw_done && !done_d) begin
         if (res_q.size() == 0) fail_now("unexpected_done");
         else check("rw_res", 32'(rw_res), 32'(res_q.pop_front()));
      end
      done_d = rw_done;
   end

   task automatic push_run(input int nwr, input int nrd, input logic res);
      for (int i = 0; i < nwr; i++) exp_q.push_back('{1'b1, addr_tab[i], data_tab[i]});
      for (int i = 0; i < nrd; i++) exp_q.push_back('{1'b0, addr_tab[i], 8'h00});
      res_q.push_back(res);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rw_done) return;
      end
      fail_now({name, "_done_timeout"});
   endtask

   task automatic wait_req(input logic lvl, input string name);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (drv_req == lvl) return;
      end
      fail_now({name, "_req_timeout"});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_drv_req"}, 32'(drv_req), 0);
      check({tag, "_drv_wr"}, 32'(drv_wr), 0);
      check({tag, "_drv_addr"}, 32'(drv_addr), 0);
      check({tag, "_drv_wdata"}, 32'(drv_wdata), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_rw_done"}, 32'(rw_done), 0);
      check({tag, "_rw_res"}, 32'(rw_res), 0);
   endtask

   initial begin
      #3;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Run A: good memory, stray start during the first write-cycle wait.
      push_run(4, 4, 1'b1);
      pulse_start();
      check("busy_after_start", 32'(busy), 1);
      wait_req(1'b0, "a_twr");
      repeat (3) @(negedge clk);
      pulse_start();
      check("twr_start_busy", 32'(busy), 1);
      check("twr_start_req", 32'(drv_req), 0);
      wait_done("a");
      check("a_busy_in_done", 32'(busy), 0);

      // Run B: rerun from DONE with the byte at 0x0000 corrupted on read.
      corrupt = 1'b1;
      push_run(4, 3, 1'b0);
      pulse_start();
      check("rerun_done_clr", 32'(rw_done), 0);
      check("rerun_busy", 32'(busy), 1);
      check("rerun_req", 32'(drv_req), 1);
      wait_done("b");
      repeat (30) @(negedge clk);
      check("b_queue_empty", 32'(exp_q.size()), 0);
      corrupt = 1'b0;

      // Run C: asynchronous reset while a read is outstanding.
      push_run(4, 1, 1'b0);
      void'(res_q.pop_back());
      pulse_start();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (drv_req && !drv_wr) break;
      end
      check("c_in_read", 32'({drv_req, drv_wr}), 32'b10);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("c_no_req_after_rst", 32'(drv_req), 0);
      check("c_queue_empty", 32'(exp_q.size()), 0);
      check("c_done_low", 32'(rw_done), 0);

      // Run D: normal run after reset.
      push_run(4, 4, 1'b1);
      pulse_start();
      wait_done("d");

`ifdef EEPROM_TEST_TIMEOUT_EN
      // Run E: driver never acks; watchdog closes the run after 20 request cycles.
      begin
         int cnt;
         ack_en = 1'b0;
         push_run(1, 0, 1'b0);
         pulse_start();
         cnt = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!drv_req) break;
            cnt++;
         end
         check("timeout_req_cycles", 32'(cnt), 20);
         wait_done("e");
         ack_en = 1'b1;
      end
`endif

      repeat (5) @(negedge clk);
      check("final_req_queue", 32'(exp_q.size()), 0);
      check("final_res_queue", 32'(res_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eeprom_rw_test_ctrl.md
EEPROM_RW_TEST_CTRL -- requirements
Module: eeprom_rw_test_ctrl

Interface
REQ-001 Parameter BYTE_NUM, default 256: bytes written then read back per test run, 1..65536.
REQ-002 Parameter START_ADDR, default 16'h0000: first EEPROM byte address.
REQ-003 Parameter TWR_CYCLES, default 250000: write-cycle wait after each byte write (5 ms at 50 MHz).
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000: ack watchdog limit (used only per REQ-025).
REQ-005 clk  input  1  system clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse, begins a test run.
REQ-007 drv_req  output  1  byte-operation request to the EEPROM byte driver.
REQ-008 drv_wr  output  1  1 = write, 0 = read; valid while drv_req=1.
REQ-009 drv_addr  output  16  byte address; valid while drv_req=1.
REQ-010 drv_wdata  output  8  write data; valid while drv_req=1 and drv_wr=1.
REQ-011 drv_ack  input  1  one-cycle pulse, driver operation complete.
REQ-012 drv_rdata  input  8  read data, valid in the drv_ack cycle of a read.
REQ-013 busy  output  1  high from the cycle after start until DONE is entered.
REQ-014 rw_done  output  1  level, test run finished.
REQ-015 rw_res  output  1  1 = all bytes matched, 0 = failure; meaningful only while rw_done=1.

Function
REQ-016 States: IDLE, WR_REQ, WR_TWR, RD_REQ, CHECK, DONE; all outputs registered.
REQ-017 IDLE or DONE + start=1 -> WR_REQ next cycle; offset counter cleared, rw_done and rw_res cleared.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 WR_REQ: drv_req=1, drv_wr=1, drv_addr=START_ADDR+offset (16-bit wrap), drv_wdata=offset[7:0] XOR 8'hA5; held stable until drv_ack.
REQ-020 drv_ack in WR_REQ: drv_req=0 next cycle, enter WR_TWR; count TWR_CYCLES cycles; then offset+1 and WR_REQ, or, when offset=BYTE_NUM-1, offset cleared and RD_REQ.
REQ-021 RD_REQ: drv_req=1, drv_wr=0, drv_addr=START_ADDR+offset; on drv_ack, drv_rdata captured and CHECK entered.
REQ-022 CHECK (one cycle): compare captured byte with offset[7:0] XOR 8'hA5; mismatch -> DONE with rw_res=0; match and offset=BYTE_NUM-1 -> DONE with rw_res=1; otherwise offset+1 and RD_REQ.
REQ-023 DONE: rw_done=1, rw_res held, drv_req=0, until start or reset.
REQ-024 drv_ack outside WR_REQ/RD_REQ SHALL be ignored; drv_req never reasserts in the drv_ack cycle.

Configuration
REQ-025 Macro EEPROM_TEST_TIMEOUT_EN defined: counter runs while drv_req=1; on reaching TIMEOUT_CYCLES without drv_ack -> drv_req=0, DONE with rw_res=0. Undefined: no watchdog logic, wait for drv_ack indefinitely.

Reset
REQ-026 rst_n low: state IDLE; drv_req, drv_wr, drv_addr, drv_wdata, busy, rw_done, rw_res all 0; counters 0.
REQ-027 Reset mid-operation SHALL abort immediately with no further driver requests until the next start.

Verification
REQ-028 BYTE_NUM=4, TWR_CYCLES=10, driver model acks after 3 cycles and echoes memory -> 4 writes (addr 0..3, data A5,A4,A7,A6), 4 reads, rw_done=1, rw_res=1.
REQ-029 Same, model corrupts read of addr 2 -> rw_done=1, rw_res=0, no read issued for addr 3.
REQ-030 START_ADDR=16'hFFFE, BYTE_NUM=4 -> addresses FFFE, FFFF, 0000, 0001.
REQ-031 start pulsed during WR_TWR -> no effect; second start in DONE -> rw_done=0 next cycle, full rerun.
REQ-032 rst_n asserted while drv_req=1 in RD_REQ -> all outputs 0 asynchronously, IDLE.
REQ-033 EEPROM_TEST_TIMEOUT_EN, TIMEOUT_CYCLES=20, driver never acks -> drv_req drops after 20 cycles, rw_done=1, rw_res=0.
